// File: rtl/icache_pkg.sv
// Shared types and sizing for the instruction cache.
package icache_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS = 16;
    localparam int IIDX_W      = $clog2(ICACHE_SETS);
    localparam int ITAG_W      = 30 - IIDX_W;

    // Field view of an instruction byte address for the default geometry.
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    // One cache frame for the default geometry.
    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache between fetch and the
// memory controller. Hits are combinational; a miss issues one word read and
// fills the frame selected by the address present when the read completes.
//
// Memory handshake: iREN is the request strobe and stays high while FETCH
// wants data; iload is accepted on a rising edge where iREN is high and iwait
// is low. Dropping iREN (imemREN squash) abandons the read with no fill.
module icache
    import icache_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          imemREN,
    input  word_t         imemaddr,
    input  logic          flush,
    output logic          ihit,
    output word_t         imemload,
    output logic          iREN,
    output word_t         iaddr,
    input  word_t         iload,
    input  logic          iwait,
    output word_t         hitcnt,
    output word_t         misscnt,
    output icache_state_t dbg_state
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } frame_t;

    frame_t        frames [SETS];
    icache_state_t state;
    icache_state_t next_state;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] atag;
    logic             hit;
    logic             fill;
    logic             miss_issue;
    logic             unused_byteoff;

    assign idx            = imemaddr[IDX_W+1:2];
    assign atag           = imemaddr[31:IDX_W+2];
    assign unused_byteoff = ^imemaddr[1:0];
    assign dbg_state      = state;

    // Lookup, request and fill decode for the current cycle.
    always_comb begin
        hit        = 1'b0;
        fill       = 1'b0;
        miss_issue = 1'b0;
        ihit       = 1'b0;
        iREN       = 1'b0;
        next_state = state;
        imemload   = frames[idx].data;
        iaddr      = {imemaddr[31:2], 2'b00};
        case (state)
            IDLE: begin
                hit        = imemREN && frames[idx].valid && (frames[idx].tag == atag);
                ihit       = hit;
                miss_issue = imemREN && !hit && !flush;
                if (miss_issue) next_state = FETCH;
            end
            FETCH: begin
                iREN = imemREN;
                if (!imemREN) begin
                    next_state = IDLE;
                end else if (!iwait) begin
                    fill       = !flush;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // State register; reset abandons any in-flight read.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Frame array: flush clears valids and wins over a same-cycle fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) frames[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < SETS; i++) frames[i].valid <= 1'b0;
        end else if (fill) begin
            frames[idx] <= '{valid: 1'b1, tag: atag, data: iload};
        end
    end

    // Saturating hit and miss counters, untouched by flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hitcnt  <= '0;
            misscnt <= '0;
        end else begin
            if (ihit && (hitcnt != 32'hFFFF_FFFF))        hitcnt  <= hitcnt + 32'd1;
            if (miss_issue && (misscnt != 32'hFFFF_FFFF)) misscnt <= misscnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized reads
// compared against an address-level model of cache contents and counters.
module tb_icache;
    import icache_pkg::*;

    localparam int SETS = 16;

    logic          CLK;
    logic          nRST;
    logic          imemREN;
    word_t         imemaddr;
    logic          flush;
    logic          ihit;
    word_t         imemload;
    logic          iREN;
    word_t         iaddr;
    word_t         iload;
    logic          iwait;
    word_t         hitcnt;
    word_t         misscnt;
    icache_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // Model: per frame, whether it holds a word, which word address, and data.
    bit    m_valid [SETS];
    word_t m_line  [SETS];
    word_t m_data  [SETS];
    int    m_hits   = 0;
    int    m_misses = 0;

    icache dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .flush     (flush),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iload     (iload),
        .iwait     (iwait),
        .hitcnt    (hitcnt),
        .misscnt   (misscnt),
        .dbg_state (dbg_state)
    );

    // Clock generation.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int m_index(input word_t a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic bit m_lookup(input word_t a);
        return m_valid[m_index(a)] && (m_line[m_index(a)] == (a >> 2));
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = '0;
            m_data[i]  = '0;
        end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic void m_flush();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    endfunction

    // A completed read: a hit counts once; a miss counts, fills, then hits once.
    function automatic void m_apply_read(input word_t a, input word_t d);
        if (m_lookup(a)) begin
            m_hits++;
        end else begin
            m_misses++;
            m_valid[m_index(a)] = 1'b1;
            m_line[m_index(a)]  = a >> 2;
            m_data[m_index(a)]  = d;
            m_hits++;
        end
    endfunction

    // Driver: one full read with w wait cycles; entered and left at posedge+1.
    task automatic do_read(input word_t a, input int w, input word_t d,
                           output bit first_hit, output int ren_cycles,
                           output bit final_hit, output word_t got);
        imemREN    = 1'b1;
        imemaddr   = a;
        iwait      = 1'b1;
        iload      = d;
        ren_cycles = 0;
        @(negedge CLK);
        first_hit = ihit;
        final_hit = ihit;
        got       = imemload;
        @(posedge CLK); #1;
        if (!first_hit) begin
            for (int k = 0; k <= w; k++) begin
                iwait = (k < w);
                @(negedge CLK);
                if (iREN === 1'b1) ren_cycles++;
                @(posedge CLK); #1;
            end
            iwait = 1'b1;
            @(negedge CLK);
            final_hit = ihit;
            got       = imemload;
            @(posedge CLK); #1;
        end
        imemREN = 1'b0;
    endtask

    task automatic test_reset();
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_1237;
        flush    = 1'b0;
        iwait    = 1'b1;
        iload    = 32'hDEAD_BEEF;
        m_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit: got %b want 0", ihit); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iren: got %b want 0", iREN); end
        checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload: got %h want 0", imemload); end
        checks++; if (iaddr !== 32'h0000_1234) begin errors++; $display("FAIL reset_iaddr: got %h want 00001234", iaddr); end
        checks++; if (hitcnt !== 32'h0 || misscnt !== 32'h0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hitcnt, misscnt); end
        imemREN = 1'b0;
        #2 nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_cold_read();
        bit fh; bit lh; int rc; word_t g;
        do_read(32'h0000_0040, 3, 32'h8C01_0004, fh, rc, lh, g);
        m_apply_read(32'h0000_0040, 32'h8C01_0004);
        checks++; if (fh !== 1'b0) begin errors++; $display("FAIL cold_first_hit: got %b want 0", fh); end
        checks++; if (rc != 4) begin errors++; $display("FAIL cold_iren_cycles: got %0d want 4", rc); end
        checks++; if (lh !== 1'b1 || g !== 32'h8C01_0004) begin errors++; $display("FAIL cold_fill: got hit %b data %h want 1 8c010004", lh, g); end
        @(negedge CLK);
        checks++; if (misscnt !== 32'd1 || hitcnt !== 32'd1) begin errors++; $display("FAIL cold_counters: got %0d/%0d want 1/1", misscnt, hitcnt); end
        @(posedge CLK); #1;
    endtask

    task automatic test_repeat_hit();
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            checks++;
            if (ihit !== 1'b1 || iREN !== 1'b0 || imemload !== m_data[m_index(32'h40)]) begin
                errors++;
                $display("FAIL repeat_hit: got ihit %b iren %b data %h want 1 0 %h", ihit, iREN, imemload, m_data[m_index(32'h40)]);
            end
            @(posedge CLK); #1;
            m_hits++;
        end
        imemREN = 1'b0;
        @(negedge CLK);
        checks++; if (hitcnt !== word_t'(m_hits)) begin errors++; $display("FAIL repeat_hitcnt: got %0d want %0d", hitcnt, m_hits); end
        @(posedge CLK); #1;
    endtask

    task automatic test_conflict();
        bit fh; bit lh; int rc; word_t g;
        do_read(32'h0000_0080, 1, 32'h1111_2222, fh, rc, lh, g);
        checks++; if (fh !== m_lookup(32'h80)) begin errors++; $display("FAIL conflict_80_hit: got %b want %b", fh, m_lookup(32'h80)); end
        m_apply_read(32'h0000_0080, 32'h1111_2222);
        checks++; if (g !== 32'h1111_2222) begin errors++; $display("FAIL conflict_80_data: got %h want 11112222", g); end
        do_read(32'h0000_0040, 0, 32'h8C01_0004, fh, rc, lh, g);
        checks++; if (fh !== m_lookup(32'h40)) begin errors++; $display("FAIL conflict_40_hit: got %b want %b", fh, m_lookup(32'h40)); end
        m_apply_read(32'h0000_0040, 32'h8C01_0004);
        @(negedge CLK);
        checks++; if (misscnt !== word_t'(m_misses)) begin errors++; $display("FAIL conflict_misscnt: got %0d want %0d", misscnt, m_misses); end
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        bit fh; bit lh; int rc; word_t g; word_t a; word_t d; int w; bit exp_hit; word_t exp_data;
        for (int n = 0; n < 60; n++) begin
            a = (word_t'($urandom_range(0, 3)) << 6) | (word_t'($urandom_range(0, 15)) << 2)
                | word_t'($urandom_range(0, 3));
            d = $urandom;
            w = $urandom_range(0, 3);
            exp_hit  = m_lookup(a);
            exp_data = exp_hit ? m_data[m_index(a)] : d;
            do_read(a, w, d, fh, rc, lh, g);
            m_apply_read(a, d);
            checks++; if (fh !== exp_hit) begin errors++; $display("FAIL rand_hit addr %h: got %b want %b", a, fh, exp_hit); end
            checks++; if (lh !== 1'b1 || g !== exp_data) begin errors++; $display("FAIL rand_data addr %h: got hit %b data %h want 1 %h", a, lh, g, exp_data); end
            if (!exp_hit) begin
                checks++; if (rc != w + 1) begin errors++; $display("FAIL rand_iren_cycles addr %h: got %0d want %0d", a, rc, w + 1); end
            end
        end
        @(negedge CLK);
        checks++; if (hitcnt !== word_t'(m_hits) || misscnt !== word_t'(m_misses)) begin errors++; $display("FAIL rand_counters: got %0d/%0d want %0d/%0d", hitcnt, misscnt, m_hits, m_misses); end
        @(posedge CLK); #1;
    endtask

    task automatic test_squash();
        bit fh; bit lh; int rc; word_t g;
        word_t a = 32'h0000_11C8;
        m_valid[m_index(a)] = m_valid[m_index(a)];
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        @(negedge CLK);
        checks++; if (ihit !== m_lookup(a)) begin errors++; $display("FAIL squash_first_hit: got %b want %b", ihit, m_lookup(a)); end
        @(posedge CLK); #1;
        m_misses++;
        @(negedge CLK);
        checks++; if (iREN !== 1'b1 || iaddr !== a) begin errors++; $display("FAIL squash_fetch_req: got iren %b iaddr %h want 1 %h", iREN, iaddr, a); end
        @(posedge CLK); #1;
        imemREN = 1'b0;
        iload   = 32'hBAD0_BAD0;
        iwait   = 1'b0;
        @(negedge CLK);
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL squash_iren: got %b want 0", iREN); end
        @(posedge CLK); #1;
        iwait = 1'b1;
        do_read(a, 1, 32'h5A5A_0001, fh, rc, lh, g);
        checks++; if (fh !== 1'b0) begin errors++; $display("FAIL squash_no_fill: got hit %b want 0", fh); end
        m_apply_read(a, 32'h5A5A_0001);
        @(negedge CLK);
        checks++; if (misscnt !== word_t'(m_misses)) begin errors++; $display("FAIL squash_misscnt: got %0d want %0d", misscnt, m_misses); end
        @(posedge CLK); #1;
    endtask

    task automatic test_flush();
        bit fh; bit lh; int rc; word_t g;
        word_t f = 32'h0000_02C8;
        do_read(32'h40, 0, 32'hAAAA_0040, fh, rc, lh, g); m_apply_read(32'h40, 32'hAAAA_0040);
        do_read(32'h44, 0, 32'hAAAA_0044, fh, rc, lh, g); m_apply_read(32'h44, 32'hAAAA_0044);
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        m_flush();
        do_read(32'h40, 1, 32'hBBBB_0040, fh, rc, lh, g);
        checks++; if (fh !== 1'b0) begin errors++; $display("FAIL flush_40_miss: got hit %b want 0", fh); end
        m_apply_read(32'h40, 32'hBBBB_0040);
        do_read(32'h44, 1, 32'hBBBB_0044, fh, rc, lh, g);
        checks++; if (fh !== 1'b0) begin errors++; $display("FAIL flush_44_miss: got hit %b want 0", fh); end
        m_apply_read(32'h44, 32'hBBBB_0044);

        // Flush coinciding with the completing fill.
        imemREN  = 1'b1;
        imemaddr = f;
        iwait    = 1'b1;
        iload    = 32'hCCCC_02C8;
        @(posedge CLK); #1;
        m_misses++;
        iwait = 1'b0;
        flush = 1'b1;
        @(negedge CLK);
        checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL flush_fill_iren: got %b want 1", iREN); end
        @(posedge CLK); #1;
        m_flush();
        flush   = 1'b0;
        imemREN = 1'b0;
        iwait   = 1'b1;
        @(negedge CLK);
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL flush_fill_state: got %0d want IDLE", dbg_state); end
        @(posedge CLK); #1;
        do_read(f, 0, 32'hDDDD_02C8, fh, rc, lh, g);
        checks++; if (fh !== 1'b0) begin errors++; $display("FAIL flush_fill_discarded: got hit %b want 0", fh); end
        m_apply_read(f, 32'hDDDD_02C8);

        // Flush coinciding with a hit: hit counts, frame gone afterward.
        do_read(32'h40, 0, 32'hEEEE_0040, fh, rc, lh, g); m_apply_read(32'h40, 32'hEEEE_0040);
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        flush    = 1'b1;
        @(negedge CLK);
        checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL flush_hit_ihit: got %b want 1", ihit); end
        @(posedge CLK); #1;
        m_hits++;
        m_flush();
        flush   = 1'b0;
        imemREN = 1'b0;
        @(negedge CLK);
        checks++; if (hitcnt !== word_t'(m_hits)) begin errors++; $display("FAIL flush_hit_count: got %0d want %0d", hitcnt, m_hits); end
        @(posedge CLK); #1;
        do_read(32'h40, 0, 32'hFFFF_0040, fh, rc, lh, g);
        checks++; if (fh !== 1'b0) begin errors++; $display("FAIL flush_hit_invalidated: got hit %b want 0", fh); end
        m_apply_read(32'h40, 32'hFFFF_0040);

        // Flush coinciding with a miss in IDLE: no fetch, no count.
        imemREN  = 1'b1;
        imemaddr = 32'h3C0;
        flush    = 1'b1;
        @(posedge CLK); #1;
        m_flush();
        flush   = 1'b0;
        imemREN = 1'b0;
        @(negedge CLK);
        checks++; if (dbg_state !== IDLE || misscnt !== word_t'(m_misses)) begin errors++; $display("FAIL flush_miss: got state %0d misscnt %0d want IDLE %0d", dbg_state, misscnt, m_misses); end
        @(posedge CLK); #1;
    endtask

    task automatic test_async_reset();
        bit fh; bit lh; int rc; word_t g;
        do_read(32'h40, 0, 32'h1234_0040, fh, rc, lh, g); m_apply_read(32'h40, 32'h1234_0040);
        imemREN  = 1'b1;
        imemaddr = 32'h48;
        iwait    = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL areset_pre_iren: got %b want 1", iREN); end
        #1 nRST = 1'b0;
        #1;
        checks++; if (iREN !== 1'b0 || ihit !== 1'b0) begin errors++; $display("FAIL areset_outputs: got iren %b ihit %b want 0 0", iREN, ihit); end
        checks++; if (hitcnt !== 32'h0 || misscnt !== 32'h0) begin errors++; $display("FAIL areset_counters: got %0d/%0d want 0/0", hitcnt, misscnt); end
        m_reset();
        imemREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        do_read(32'h40, 0, 32'h0BAD_0040, fh, rc, lh, g);
        checks++; if (fh !== 1'b0) begin errors++; $display("FAIL areset_40_invalid: got hit %b want 0", fh); end
        m_apply_read(32'h40, 32'h0BAD_0040);
        do_read(32'h2C8, 0, 32'h0BAD_02C8, fh, rc, lh, g);
        checks++; if (fh !== 1'b0) begin errors++; $display("FAIL areset_2c8_invalid: got hit %b want 0", fh); end
        m_apply_read(32'h2C8, 32'h0BAD_02C8);
        @(negedge CLK);
        checks++; if (hitcnt !== word_t'(m_hits) || misscnt !== word_t'(m_misses)) begin errors++; $display("FAIL areset_final_counters: got %0d/%0d want %0d/%0d", hitcnt, misscnt, m_hits, m_misses); end
        @(posedge CLK); #1;
    endtask

    // Scenario sequence and final report.
    initial begin
        test_reset();
        test_cold_read();
        test_repeat_hit();
        test_conflict();
        test_squash();
        test_flush();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
